// File: rtl/sdram_cmd_decoder.sv
// SDRAM command-bus decoder: tracks bank/row state and mode register, and
// turns legal READ/WRITE commands into a stream of per-beat access records.
module sdram_cmd_decoder #(
    parameter int CL_DEFAULT = 2,
    parameter int BL_DEFAULT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        CS_n,
    input  logic        RAS_n,
    input  logic        CAS_n,
    input  logic        WE_n,
    input  logic [1:0]  BS,
    input  logic [9:0]  A,
    output logic        AccValid,
    output logic        AccWrite,
    output logic [21:0] AccAddr,
    output logic        BurstLast,
    output logic        CmdErr,
    output logic [3:0]  BankOpen
);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    cmd_e cmd;

    logic [3:0]  bank_open_q, bank_open_d;
    logic [9:0]  row_q [4];
    logic [9:0]  row_d [4];
    logic [3:0]  bl_q, bl_d;
    logic [1:0]  cl_q, cl_d;

    logic        burst_q, burst_d;
    logic [1:0]  wait_q, wait_d;
    logic [2:0]  beat_q, beat_d;
    logic [1:0]  b_bank_q, b_bank_d;
    logic [9:0]  b_row_q, b_row_d;
    logic [9:0]  b_col_q, b_col_d;
    logic        b_write_q, b_write_d;
    logic [3:0]  b_bl_q, b_bl_d;

    logic        valid_q, valid_d;
    logic        write_q, write_d;
    logic [21:0] addr_q, addr_d;
    logic        last_q, last_d;
    logic        err_q, err_d;

    logic [9:0]  col_mask;
    logic [9:0]  beat_col;

    always_comb begin
        cmd = CS_n ? CMD_NOP : cmd_e'({RAS_n, CAS_n, WE_n});
    end

    // Column wraps inside the BL-aligned block: high bits from the start
    // column, low bits are (start + beat) mod BL.
    always_comb begin
        col_mask = {6'd0, b_bl_q - 4'd1};
        beat_col = (b_col_q & ~col_mask) | ((b_col_q + {7'd0, beat_q}) & col_mask);
    end

    always_comb begin
        bank_open_d = bank_open_q;
        row_d       = row_q;
        bl_d        = bl_q;
        cl_d        = cl_q;
        burst_d     = burst_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        b_bank_d    = b_bank_q;
        b_row_d     = b_row_q;
        b_col_d     = b_col_q;
        b_write_d   = b_write_q;
        b_bl_d      = b_bl_q;
        valid_d     = 1'b0;
        write_d     = 1'b0;
        addr_d      = '0;
        last_d      = 1'b0;
        err_d       = 1'b0;

        if (burst_q) begin
            if (wait_q != 2'd0) begin
                wait_d = wait_q - 2'd1;
            end else begin
                valid_d = 1'b1;
                write_d = b_write_q;
                addr_d  = {b_bank_q, b_row_q, beat_col};
                last_d  = (beat_q == 3'(b_bl_q - 4'd1));
                beat_d  = beat_q + 3'd1;
                if (last_d) begin
                    burst_d = 1'b0;
                end
            end
        end

        // A command that discards the burst also suppresses the beat that
        // would otherwise have been presented after this same edge.
        case (cmd)
            CMD_ACT: begin
                if (bank_open_q[BS]) begin
                    err_d = 1'b1;
                end else begin
                    bank_open_d[BS] = 1'b1;
                    row_d[BS]       = A;
                end
            end
            CMD_PRE: begin
                if (A[9] || (burst_q && b_bank_q == BS)) begin
                    burst_d = 1'b0;
                    valid_d = 1'b0;
                    write_d = 1'b0;
                    addr_d  = '0;
                    last_d  = 1'b0;
                end
                if (A[9]) begin
                    bank_open_d = '0;
                end else begin
                    bank_open_d[BS] = 1'b0;
                end
            end
            CMD_REF: begin
                err_d = |bank_open_q;
            end
            CMD_MRS: begin
                if (|bank_open_q) begin
                    err_d = 1'b1;
                end else begin
                    case (A[2:0])
                        3'b001:  bl_d = 4'd2;
                        3'b010:  bl_d = 4'd4;
                        3'b011:  bl_d = 4'd8;
                        default: bl_d = 4'd1;
                    endcase
                    cl_d = (A[6:4] == 3'd3) ? 2'd3 : 2'd2;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!bank_open_q[BS]) begin
                    err_d = 1'b1;
                end else begin
                    burst_d   = 1'b1;
                    wait_d    = (cmd == CMD_WR) ? 2'd0 : cl_q - 2'd1;
                    beat_d    = '0;
                    b_bank_d  = BS;
                    b_row_d   = row_q[BS];
                    b_col_d   = A;
                    b_write_d = (cmd == CMD_WR);
                    b_bl_d    = bl_q;
                    valid_d   = 1'b0;
                    write_d   = 1'b0;
                    addr_d    = '0;
                    last_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank_open_q <= '0;
            row_q       <= '{default: '0};
            bl_q        <= 4'(BL_DEFAULT);
            cl_q        <= 2'(CL_DEFAULT);
            burst_q     <= 1'b0;
            wait_q      <= '0;
            beat_q      <= '0;
            b_bank_q    <= '0;
            b_row_q     <= '0;
            b_col_q     <= '0;
            b_write_q   <= 1'b0;
            b_bl_q      <= 4'd1;
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bank_open_q <= bank_open_d;
            row_q       <= row_d;
            bl_q        <= bl_d;
            cl_q        <= cl_d;
            burst_q     <= burst_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            b_bank_q    <= b_bank_d;
            b_row_q     <= b_row_d;
            b_col_q     <= b_col_d;
            b_write_q   <= b_write_d;
            b_bl_q      <= b_bl_d;
            valid_q     <= valid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign AccValid  = valid_q;
    assign AccWrite  = write_q;
    assign AccAddr   = addr_q;
    assign BurstLast = last_q;
    assign CmdErr    = err_q;
    assign BankOpen  = bank_open_q;

endmodule
